// File: rtl/cordic_quadrant_map.sv
// cordic_quadrant_map
//   Quadrant pre-rotation ahead of the CORDIC iteration chain.
//   Rotation mode folds the phase into +/-90 deg by negating x/y and
//   dropping the z MSB; vectoring mode folds the vector into the right
//   half-plane and adds a half-turn to z.
//   Two-stage pipeline with valid/ready handshake and a channel tag.
//
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready is combinational
//                            from out_ready)
//   in_mode                  0 = rotation, 1 = vectoring
//   in_chan, xin, yin, zin   channel tag, signed x/y, phase word
//   out_valid/out_ready      output handshake
//   xout, yout, zout         mapped x/y, mapped phase (Z_WIDTH+Z_GUARD_BITS)
//   out_chan, out_flip       tag and "x/y negated" flag of the output sample
//   neg_ovf                  sticky: a flipped sample held the most-negative
//                            x/y value; cleared only by reset
//
// Build option:
//   CORDIC_QMAP_SAT_EN       when defined, negation saturates instead of
//                            wrapping.
module cordic_quadrant_map #(
    parameter int XY_WIDTH     = 16,
    parameter int Z_WIDTH      = 16,
    parameter int Z_GUARD_BITS = 0,
    parameter int CHAN_BITS    = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_mode,
    input  logic [CHAN_BITS-1:0]              in_chan,
    input  logic signed [XY_WIDTH-1:0]        xin,
    input  logic signed [XY_WIDTH-1:0]        yin,
    input  logic [Z_WIDTH-1:0]                zin,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [XY_WIDTH-1:0]        xout,
    output logic signed [XY_WIDTH-1:0]        yout,
    output logic [Z_WIDTH+Z_GUARD_BITS-1:0]   zout,
    output logic [CHAN_BITS-1:0]              out_chan,
    output logic                              out_flip,
    output logic                              neg_ovf
);

    localparam int ZW = Z_WIDTH + Z_GUARD_BITS;
    localparam logic [XY_WIDTH-1:0] XY_MIN = {1'b1, {(XY_WIDTH-1){1'b0}}};
`ifdef CORDIC_QMAP_SAT_EN
    localparam logic [XY_WIDTH-1:0] XY_MAX = ~XY_MIN;
`endif

    // Stage 1 registers
    logic                 s1_valid_q;
    logic                 s1_flip_q;
    logic                 s1_mode_q;
    logic [CHAN_BITS-1:0] s1_chan_q;
    logic [XY_WIDTH-1:0]  s1_x_q;
    logic [XY_WIDTH-1:0]  s1_y_q;
    logic [Z_WIDTH-1:0]   s1_z_q;
    logic                 s1_xmin_q;
    logic                 s1_ymin_q;

    // Stage 2 (output) registers
    logic                 out_valid_q;
    logic [XY_WIDTH-1:0]  xout_q;
    logic [XY_WIDTH-1:0]  yout_q;
    logic [ZW-1:0]        zout_q;
    logic [CHAN_BITS-1:0] out_chan_q;
    logic                 out_flip_q;
    logic                 neg_ovf_q;

    logic                 s1_flip_d;
    logic                 s2_advance;
    logic [XY_WIDTH-1:0]  xout_d;
    logic [XY_WIDTH-1:0]  yout_d;
    logic [ZW-1:0]        zout_d;
    logic                 ztop;

    // Stage 2 can take a new sample when it is empty or is emitting now.
    assign s2_advance = !out_valid_q || out_ready;
    assign in_ready   = reset || !s1_valid_q || s2_advance;

    assign s1_flip_d = in_mode ? xin[XY_WIDTH-1]
                               : (zin[Z_WIDTH-1] ^ zin[Z_WIDTH-2]);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_flip_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_chan_q  <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_z_q     <= '0;
            s1_xmin_q  <= 1'b0;
            s1_ymin_q  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_flip_q <= s1_flip_d;
                s1_mode_q <= in_mode;
                s1_chan_q <= in_chan;
                s1_x_q    <= xin;
                s1_y_q    <= yin;
                s1_z_q    <= zin;
                s1_xmin_q <= (xin == XY_MIN);
                s1_ymin_q <= (yin == XY_MIN);
            end
        end
    end

    always_comb begin
        xout_d = s1_x_q;
        yout_d = s1_y_q;
        if (s1_flip_q) begin
`ifdef CORDIC_QMAP_SAT_EN
            xout_d = s1_xmin_q ? XY_MAX : -s1_x_q;
            yout_d = s1_ymin_q ? XY_MAX : -s1_y_q;
`else
            xout_d = -s1_x_q;
            yout_d = -s1_y_q;
`endif
        end
    end

    // Rotation: sign-extend from bit Z_WIDTH-2 (MSB dropped).
    // Vectoring: MSB toggled by flip (half-turn add), then sign-extended.
    assign ztop   = s1_mode_q ? (s1_z_q[Z_WIDTH-1] ^ s1_flip_q) : s1_z_q[Z_WIDTH-2];
    assign zout_d = {{(Z_GUARD_BITS+1){ztop}}, s1_z_q[Z_WIDTH-2:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            xout_q      <= '0;
            yout_q      <= '0;
            zout_q      <= '0;
            out_chan_q  <= '0;
            out_flip_q  <= 1'b0;
            neg_ovf_q   <= 1'b0;
        end else if (s2_advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                xout_q     <= xout_d;
                yout_q     <= yout_d;
                zout_q     <= zout_d;
                out_chan_q <= s1_chan_q;
                out_flip_q <= s1_flip_q;
                if (s1_flip_q && (s1_xmin_q || s1_ymin_q))
                    neg_ovf_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign xout      = xout_q;
    assign yout      = yout_q;
    assign zout      = zout_q;
    assign out_chan  = out_chan_q;
    assign out_flip  = out_flip_q;
    assign neg_ovf   = neg_ovf_q;

endmodule

// File: doc/cordic_quadrant_map.md
Name: cordic_quadrant_map

Overview:
Parametrised quadrant pre-rotation stage placed ahead of the CORDIC iteration chain in the DDC/DUC paths. In rotation mode it folds the phase into ±90° by negating x/y and trimming the z MSB. In vectoring mode it folds the vector into the right half-plane and adds a half-turn to z. It is a 2-stage pipeline with a valid/ready handshake and a channel tag, so one instance serves time-multiplexed channels with backpressure.

Parameters:
XY_WIDTH, 16, width of signed x/y samples
Z_WIDTH, 16, width of input phase word (two's-complement turn fraction)
Z_GUARD_BITS, 0, extra sign bits prepended to zout
CHAN_BITS, 2, width of channel tag carried alongside each sample

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept the sample this cycle
in_mode  in  1  0 = rotation, 1 = vectoring
in_chan  in  CHAN_BITS  channel tag
xin  in  XY_WIDTH  signed x
yin  in  XY_WIDTH  signed y
zin  in  Z_WIDTH  phase
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
xout  out  XY_WIDTH  signed mapped x
yout  out  XY_WIDTH  signed mapped y
zout  out  ZO  mapped phase; ZO = Z_WIDTH-1+Z_GUARD_BITS in rotation semantics, carried in a register of width Z_WIDTH+Z_GUARD_BITS (see Behaviour)
out_chan  out  CHAN_BITS  tag of the output sample
out_flip  out  1  1 if x/y were negated for this sample
neg_ovf  out  1  sticky flag: a flipped sample contained the most-negative XY value

Behaviour:
- One clock (clock); reset is synchronous and active-high, sampled on the clock edge.
- zout register width ZW = Z_WIDTH+Z_GUARD_BITS.
- Flip decision in stage 1:
  - rotation: flip = zin[Z_WIDTH-1] ^ zin[Z_WIDTH-2].
  - vectoring: flip = xin[XY_WIDTH-1], i.e. x negative.
- Stage 1 registers flip, mode, chan, the raw x/y/z and per-operand min-value detects.
- Stage 2 registers the results:
  - xout/yout = flip ? -x : x.
  - rotation: zout = zin[Z_WIDTH-2:0] sign-extended from bit Z_WIDTH-2 to ZW.
  - vectoring: zout = {zin[Z_WIDTH-1]^flip, zin[Z_WIDTH-2:0]} sign-extended to ZW. This is a half-turn add, modulo one turn.
- Latency: 2 cycles from an accepted input to out_valid when out_ready is held high. Throughput is 1 sample/cycle.
- Handshake:
  - Transfer occurs when valid && ready. A stage advances when it is empty or its downstream stage advances.
  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable. No sample is dropped or duplicated, and samples leave in order.
- Simultaneous accept and emit with both stages full: the pipeline shifts; in_ready stays 1.
- Negating the most-negative value (-2^(XY_WIDTH-1)) wraps to itself. neg_ovf sets on the cycle that sample enters stage 2 and is cleared only by reset.
- Reset values: out_valid=0, xout=0, yout=0, zout=0, out_chan=0, out_flip=0, neg_ovf=0, all internal valids=0.
- in_ready is 1 during reset.
- Reset mid-operation discards all in-flight samples. No output is produced for them.

Optional Feature:
CORDIC_QMAP_SAT_EN
- Defined: negation saturates, so -2^(XY_WIDTH-1) maps to 2^(XY_WIDTH-1)-1. neg_ovf still sets.
- Undefined: two's-complement wrap as above.
- Latency and handshake are identical in both builds.

Test Plan:
Defaults in all cases (XY=16, Z=16, G=0, ZW=16).
1. Rotation, zin=0x4000, x=100, y=-50, out_ready=1 -> 2 cycles later out_valid=1, xout=-100, yout=50, zout=0xC000 (-90°), out_flip=1.
2. Rotation, zin=0x2000, x=7, y=9 -> xout=7, yout=9, zout=0x2000, out_flip=0.
3. Vectoring, x=-200, y=300, zin=0x0000 -> xout=200, yout=-300, zout=0x8000, out_flip=1. Then x=5, zin=0x1000 -> passthrough, zout=0x1000.
4. Backpressure: out_ready=0, present 3 back-to-back samples with chan 0,1,2:
   - first two accepted, then in_ready=0; outputs hold chan 0 stable.
   - raise out_ready -> chan 0,1,2 emerge on consecutive cycles, no loss.
5. Rotation, zin=0x8000, x=-32768 -> xout=-32768 (saturating build: 32767), neg_ovf=1 and it stays 1 over the next 10 samples.
6. Both stages full with neg_ovf=1, assert reset for 1 cycle -> next cycle out_valid=0, all outputs 0, neg_ovf=0, in_ready=1. The flushed samples never appear.
